// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR unit: addresses, op codes, WARL masks.
package csr_pkg;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
  localparam logic [31:0] MSTATUS_RST   = 32'h0000_1800;
  localparam logic [31:0] MIE_WMASK     = 32'h0000_0888;

  function automatic logic [31:0] csr_apply(csr_op_e op, logic [31:0] old_v, logic [31:0] wdata);
    logic [31:0] res;
    case (op)
      CSR_OP_RW: res = wdata;
      CSR_OP_RS: res = old_v | wdata;
      CSR_OP_RC: res = old_v & ~wdata;
      default:   res = old_v;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit counter with per-half write; any half write suppresses that cycle's increment.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] cnt_o
);

  logic [63:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo_i || wr_hi_i) begin
      if (wr_lo_i) cnt_d[31:0]  = wdata_i;
      if (wr_hi_i) cnt_d[63:32] = wdata_i;
    end else if (inc_i) begin
      cnt_d = cnt_q + 64'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file with trap entry / mret sequencing and fetch redirect.
// Optional macro CSR_COUNTERS_EN builds mcycle/minstret; otherwise they read 0.
module csr_unit
  import csr_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter logic [31:0] HART_ID  = 32'd0,
  parameter logic [31:0] MISA_VAL = 32'h4000_0100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic            csr_src_zero,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic            retire,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_val,
  input  logic            mret,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            mstatus_mie
);

  csr_op_e op;
  assign op = csr_op_e'(csr_op);

  logic        mie_q, mie_d, mpie_q, mpie_d;
  logic [31:0] mie_en_q, mie_en_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;

  logic [63:0] mcycle, minstret;
  logic [31:0] mstatus_val, rd_val, wr_val;
  logic        impl, is_write, wr_en;

  assign mstatus_val = MSTATUS_RST | {24'b0, mpie_q, 3'b0, mie_q, 3'b0};

  always_comb begin
    impl   = 1'b1;
    rd_val = '0;
    case (csr_addr)
      CSR_MSTATUS:                 rd_val = mstatus_val;
      CSR_MISA:                    rd_val = MISA_VAL;
      CSR_MIE:                     rd_val = mie_en_q;
      CSR_MTVEC:                   rd_val = mtvec_q;
      CSR_MSCRATCH:                rd_val = mscratch_q;
      CSR_MEPC:                    rd_val = mepc_q;
      CSR_MCAUSE:                  rd_val = mcause_q;
      CSR_MTVAL:                   rd_val = mtval_q;
      CSR_MIP:                     rd_val = '0;
      CSR_MCYCLE,   CSR_CYCLE:     rd_val = mcycle[31:0];
      CSR_MCYCLEH,  CSR_CYCLEH:    rd_val = mcycle[63:32];
      CSR_MINSTRET, CSR_INSTRET:   rd_val = minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: rd_val = minstret[63:32];
      CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: rd_val = '0;
      CSR_MHARTID:                 rd_val = HART_ID;
      default:                     impl   = 1'b0;
    endcase
  end

  // RS/RC with a zero source are pure reads, so they stay legal on read-only CSRs.
  assign is_write    = (op == CSR_OP_RW) ||
                       (((op == CSR_OP_RS) || (op == CSR_OP_RC)) && !csr_src_zero);
  assign csr_illegal = (op != CSR_OP_NONE) &&
                       (!impl || (is_write && (csr_addr[11:10] == 2'b11)));
  assign csr_rdata   = csr_illegal ? '0 : rd_val;
  assign wr_val      = csr_apply(op, rd_val, csr_wdata);
  assign wr_en       = (op != CSR_OP_NONE) && is_write && !csr_illegal && !trap && !mret;

  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mie_en_d   = mie_en_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    if (trap) begin
      mepc_d   = trap_pc & ~32'h3;
      mcause_d = trap_cause;
      mtval_d  = trap_val;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (mret) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (wr_en) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mie_d  = wr_val[3];
          mpie_d = wr_val[7];
        end
        CSR_MIE:      mie_en_d   = wr_val & MIE_WMASK;
        CSR_MTVEC:    mtvec_d    = wr_val & ~32'h3;
        CSR_MSCRATCH: mscratch_d = wr_val;
        CSR_MEPC:     mepc_d     = wr_val & ~32'h3;
        CSR_MCAUSE:   mcause_d   = wr_val;
        CSR_MTVAL:    mtval_d    = wr_val;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mie_en_q   <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mie_en_q   <= mie_en_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
    end
  end

`ifdef CSR_COUNTERS_EN
  csr_counter64 u_mcycle (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (1'b1),
    .wr_lo_i (wr_en && (csr_addr == CSR_MCYCLE)),
    .wr_hi_i (wr_en && (csr_addr == CSR_MCYCLEH)),
    .wdata_i (wr_val),
    .cnt_o   (mcycle)
  );

  csr_counter64 u_minstret (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (retire),
    .wr_lo_i (wr_en && (csr_addr == CSR_MINSTRET)),
    .wr_hi_i (wr_en && (csr_addr == CSR_MINSTRETH)),
    .wdata_i (wr_val),
    .cnt_o   (minstret)
  );
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign mcycle        = '0;
  assign minstret      = '0;
`endif

  assign redirect_valid = !rst && (trap || mret);
  assign redirect_pc    = trap ? mtvec_q : mepc_q;
  assign mstatus_mie    = mie_q;

endmodule

// File: tb/tb_csr_unit.sv
// Directed self-checking bench for csr_unit: vector table plus trap/counter/reset sequences.
module tb_csr_unit;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;
  localparam logic [31:0] HART   = 32'd0;
`ifdef CSR_COUNTERS_EN
  localparam bit CNT = 1'b1;
`else
  localparam bit CNT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_src_zero;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        retire, trap, mret;
  logic [31:0] trap_cause, trap_pc, trap_val;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mstatus_mie;

  int tests  = 0;
  int errors = 0;

  always #5 clk = ~clk;

  csr_unit #(.XLEN(32), .HART_ID(HART), .MISA_VAL(32'h4000_0100)) dut (
    .clk(clk), .rst(rst), .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_src_zero(csr_src_zero), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .retire(retire), .trap(trap), .trap_cause(trap_cause), .trap_pc(trap_pc),
    .trap_val(trap_val), .mret(mret), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .mstatus_mie(mstatus_mie)
  );

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        sz;
    logic [31:0] exp_rd;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    csr_op = OP_NONE; csr_addr = '0; csr_wdata = '0; csr_src_zero = 1'b0;
    retire = 1'b0; trap = 1'b0; mret = 1'b0;
    trap_cause = '0; trap_pc = '0; trap_val = '0;
  endtask

  // Drive one CSR access on the falling edge; it commits at the next rising edge.
  task automatic drive(input logic [1:0] op, input logic [11:0] addr,
                       input logic [31:0] wd, input logic sz);
    @(negedge clk);
    idle();
    csr_op = op; csr_addr = addr; csr_wdata = wd; csr_src_zero = sz;
    #1;
  endtask

  task automatic rd(input string name, input logic [11:0] addr, input logic [31:0] exp);
    drive(OP_NONE, addr, '0, 1'b0);
    check(name, csr_rdata, exp);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    csr_addr = 12'h300;
    trap = 1'b1;
    #1;
    check("rst_redirect", {31'b0, redirect_valid}, 32'h0);
    check("rst_mie_out", {31'b0, mstatus_mie}, 32'h0);
    trap = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // op, addr, wdata, src_zero, expected rdata, expected illegal
    vecs.push_back('{OP_RS, 12'h300, 32'h0, 1'b1, 32'h0000_1800, 1'b0});
    vecs.push_back('{OP_RS, 12'h301, 32'h0, 1'b1, 32'h4000_0100, 1'b0});
    vecs.push_back('{OP_RS, 12'hF14, 32'h0, 1'b1, HART,          1'b0});
    vecs.push_back('{OP_RW, 12'h305, 32'h8000_0103, 1'b0, 32'h0, 1'b0});
    vecs.push_back('{OP_RS, 12'h305, 32'h0, 1'b1, 32'h8000_0100, 1'b0});
    vecs.push_back('{OP_RW, 12'h340, 32'hF0, 1'b0, 32'h0,  1'b0});
    vecs.push_back('{OP_RS, 12'h340, 32'hFF, 1'b1, 32'hF0, 1'b0});
    vecs.push_back('{OP_RS, 12'h340, 32'h0F, 1'b0, 32'hF0, 1'b0});
    vecs.push_back('{OP_RC, 12'h340, 32'h3C, 1'b0, 32'hFF, 1'b0});
    vecs.push_back('{OP_RS, 12'h340, 32'h0,  1'b1, 32'hC3, 1'b0});
    vecs.push_back('{OP_RW, 12'hF11, 32'h5, 1'b0, 32'h0, 1'b1});
    vecs.push_back('{OP_RS, 12'hF11, 32'h0, 1'b1, 32'h0, 1'b0});
    vecs.push_back('{OP_RW, 12'h7C0, 32'h1, 1'b0, 32'h0, 1'b1});
    vecs.push_back('{OP_RS, 12'hF14, 32'h0, 1'b1, HART,  1'b0});
    vecs.push_back('{OP_RS, 12'hF14, 32'h1, 1'b0, 32'h0, 1'b1});
    vecs.push_back('{OP_RS, 12'h340, 32'h0, 1'b1, 32'hC3, 1'b0});
    vecs.push_back('{OP_RW, 12'h304, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0});
    vecs.push_back('{OP_RS, 12'h304, 32'h0, 1'b1, 32'h888, 1'b0});
    vecs.push_back('{OP_RW, 12'h300, 32'hFFFF_FFFF, 1'b0, 32'h1800, 1'b0});
    vecs.push_back('{OP_RS, 12'h300, 32'h0, 1'b1, 32'h1888, 1'b0});
    vecs.push_back('{OP_RC, 12'h300, 32'h8, 1'b0, 32'h1888, 1'b0});
    vecs.push_back('{OP_RS, 12'h300, 32'h0, 1'b1, 32'h1880, 1'b0});
    vecs.push_back('{OP_RW, 12'h341, 32'h1234_5677, 1'b0, 32'h0, 1'b0});
    vecs.push_back('{OP_RS, 12'h341, 32'h0, 1'b1, 32'h1234_5674, 1'b0});
    vecs.push_back('{OP_RW, 12'h343, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0});
    vecs.push_back('{OP_RS, 12'h343, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{OP_RW, 12'h342, 32'h8000_000B, 1'b0, 32'h0, 1'b0});
    vecs.push_back('{OP_RS, 12'h342, 32'h0, 1'b1, 32'h8000_000B, 1'b0});
    vecs.push_back('{OP_RW, 12'h344, 32'hFFFF, 1'b0, 32'h0, 1'b0});
    vecs.push_back('{OP_RS, 12'h344, 32'h0, 1'b1, 32'h0, 1'b0});
    vecs.push_back('{OP_RW, 12'hC00, 32'h1, 1'b0, 32'h0, 1'b1});
    vecs.push_back('{OP_RW, 12'h301, 32'h0, 1'b0, 32'h4000_0100, 1'b0});
    vecs.push_back('{OP_RS, 12'h301, 32'h0, 1'b1, 32'h4000_0100, 1'b0});
    vecs.push_back('{OP_NONE, 12'h7C0, 32'h0, 1'b0, 32'h0, 1'b0});
    vecs.push_back('{OP_RW, 12'hB80, 32'h0, 1'b0, 32'h0, 1'b0});

    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].sz);
      check($sformatf("vec%0d_rdata", i), csr_rdata, vecs[i].exp_rd);
      check($sformatf("vec%0d_illegal", i), {31'b0, csr_illegal}, {31'b0, vecs[i].exp_ill});
      check($sformatf("vec%0d_redirect", i), {31'b0, redirect_valid}, 32'h0);
    end

    // Trap entry and mret
    drive(OP_RW, 12'h300, 32'h8, 1'b0);
    drive(OP_RW, 12'h305, 32'h100, 1'b0);
    @(negedge clk);
    idle();
    trap = 1'b1; trap_pc = 32'h104; trap_cause = 32'd11; trap_val = 32'h0;
    #1;
    check("trap_redirect_valid", {31'b0, redirect_valid}, 32'h1);
    check("trap_redirect_pc", redirect_pc, 32'h100);
    check("pre_trap_mie_out", {31'b0, mstatus_mie}, 32'h1);
    rd("trap_mepc", 12'h341, 32'h104);
    check("post_trap_mie_out", {31'b0, mstatus_mie}, 32'h0);
    rd("trap_mcause", 12'h342, 32'd11);
    rd("trap_mtval", 12'h343, 32'h0);
    rd("trap_mstatus", 12'h300, 32'h1880);
    @(negedge clk);
    idle();
    mret = 1'b1;
    #1;
    check("mret_redirect_valid", {31'b0, redirect_valid}, 32'h1);
    check("mret_redirect_pc", redirect_pc, 32'h104);
    rd("mret_mstatus", 12'h300, 32'h1888);
    check("mret_mie_out", {31'b0, mstatus_mie}, 32'h1);

    // Coincident trap+mret+write: only the trap lands
    drive(OP_RW, 12'h340, 32'h55, 1'b0);
    drive(OP_RW, 12'h340, 32'h99, 1'b0);
    trap = 1'b1; mret = 1'b1;
    trap_pc = 32'h203; trap_cause = 32'd2; trap_val = 32'hABC;
    #1;
    check("prio_redirect_pc", redirect_pc, 32'h100);
    rd("prio_mscratch", 12'h340, 32'h55);
    rd("prio_mepc", 12'h341, 32'h200);
    rd("prio_mcause", 12'h342, 32'd2);
    rd("prio_mtval", 12'h343, 32'hABC);
    rd("prio_mstatus", 12'h300, 32'h1880);

    // mret beats a CSR write
    drive(OP_RW, 12'h340, 32'h77, 1'b0);
    mret = 1'b1;
    #1;
    check("mretw_redirect_pc", redirect_pc, 32'h200);
    rd("mretw_mscratch", 12'h340, 32'h55);
    rd("mretw_mstatus", 12'h300, 32'h1888);

    // Counters: half writes, carry into high half, shadows
    drive(OP_RW, 12'hB80, 32'h0, 1'b0);
    drive(OP_RW, 12'hB00, 32'hFFFF_FFFF, 1'b0);
    rd("mcycle_lo", 12'hB00, CNT ? 32'hFFFF_FFFF : 32'h0);
    rd("mcycleh_carry", 12'hB80, CNT ? 32'h1 : 32'h0);
    rd("cycle_shadow", 12'hC00, CNT ? 32'h1 : 32'h0);
    rd("cycleh_shadow", 12'hC80, CNT ? 32'h1 : 32'h0);
    drive(OP_RW, 12'hB02, 32'h0, 1'b0);
    drive(OP_RW, 12'hB82, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle();
      retire = 1'b1;
    end
    rd("minstret_3", 12'hB02, CNT ? 32'h3 : 32'h0);
    rd("instret_shadow", 12'hC02, CNT ? 32'h3 : 32'h0);
    drive(OP_RW, 12'hB02, 32'h10, 1'b0);
    retire = 1'b1;
    rd("minstret_wr_suppress", 12'hB02, CNT ? 32'h10 : 32'h0);
    @(negedge clk);
    idle();
    trap = 1'b1; retire = 1'b1; trap_pc = 32'h300;
    rd("minstret_trap_retire", 12'hB02, CNT ? 32'h11 : 32'h0);
    rd("minstreth", 12'hB82, 32'h0);

    // Asynchronous reset in the middle of a trap cycle
    drive(OP_RW, 12'h300, 32'h8, 1'b0);
    @(negedge clk);
    idle();
    trap = 1'b1; trap_pc = 32'h400;
    #1;
    check("midrst_pre_mie_out", {31'b0, mstatus_mie}, 32'h1);
    rst = 1'b1;
    #1;
    check("midrst_redirect", {31'b0, redirect_valid}, 32'h0);
    check("midrst_mie_out", {31'b0, mstatus_mie}, 32'h0);
    @(negedge clk);
    idle();
    rst = 1'b0;
    rd("midrst_mstatus", 12'h300, 32'h1800);
    rd("midrst_mtvec", 12'h305, 32'h0);
    rd("midrst_mscratch", 12'h340, 32'h0);
    rd("midrst_mepc", 12'h341, 32'h0);
    rd("midrst_mie", 12'h304, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0x%08h expected 0x%08h", 32'h1, 32'h0);
    $fatal(1, "timeout");
  end

endmodule
